// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU constants, load-type codes and MEM/WB state encoding
// Contents:
//   DW, AW       : default datapath and register-address widths
//   load_type_e  : load-type codes carried down from decode (values 5-7 unused)
//   wb_state_e   : MEM/WB stage state encoding
package cpu_defs;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LB  = 3'd1,
        LT_LBU = 3'd2,
        LT_LH  = 3'd3,
        LT_LHU = 3'd4
    } load_type_e;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_DATA = 1'b1
    } wb_state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - MEM/WB boundary bundle: MEM inputs, dcache return, regfile write port
// Signals:
//   mem_valid/mem_regwrite/mem_memtoreg/mem_wa/mem_alu_result/mem_load_type : MEM stage
//   dc_data_ok/dc_rdata : data cache read return
//   flush               : kill the instruction being accepted
//   wb_stall            : freeze IF..MEM while a load waits for data
//   we3/wa3/wd3         : register file write port
//   fwd_valid           : wa3/wd3 hold a forwardable write
// Modports: master = MEM/cache/pipeline side, slave = the MEM/WB stage.
interface mem_wb_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          mem_valid;
    logic          mem_regwrite;
    logic          mem_memtoreg;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_alu_result;
    logic [2:0]    mem_load_type;
    logic          dc_data_ok;
    logic [DW-1:0] dc_rdata;
    logic          flush;
    logic          wb_stall;
    logic          we3;
    logic [AW-1:0] wa3;
    logic [DW-1:0] wd3;
    logic          fwd_valid;

    modport master (
        output mem_valid, mem_regwrite, mem_memtoreg, mem_wa, mem_alu_result,
               mem_load_type, dc_data_ok, dc_rdata, flush,
        input  wb_stall, we3, wa3, wd3, fwd_valid
    );

    modport slave (
        input  mem_valid, mem_regwrite, mem_memtoreg, mem_wa, mem_alu_result,
               mem_load_type, dc_data_ok, dc_rdata, flush,
        output wb_stall, we3, wa3, wd3, fwd_valid
    );
endinterface

// File: rtl/load_extract.sv
// rtl/load_extract.sv - little-endian byte/halfword extraction and sign/zero extension of a load word
// Ports:
//   word_i   in  32  raw word from the data cache (or uncached path)
//   addr_i   in  2   low effective-address bits
//   type_i   in  3   load type code (5-7 treated as LW)
//   result_o out 32  extended load result
module load_extract
    import cpu_defs::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  type_i,
    output logic [31:0] result_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        // addr_i[0] is ignored for halfwords; misalignment is trapped upstream
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

        case (type_i)
            LT_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  result_o = {24'd0, byte_sel};
            LT_LH:   result_o = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  result_o = {16'd0, half_sel};
            default: result_o = word_i;
        endcase
    end
endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load-data collection and miss stall
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset
//   bus  slave mem_wb_stage_if: MEM inputs, dcache return, flush, stall and regfile write port
// The regfile write appears one cycle after acceptance (or after dc_data_ok for a
// missed load). wb_stall is combinational so the front end freezes in the same
// cycle the miss is seen and releases in the same cycle the data arrives.
module mem_wb_stage #(
    parameter int DW = cpu_defs::DW,
    parameter int AW = cpu_defs::AW
) (
    input  logic             clk,
    input  logic             rst,
    mem_wb_stage_if.slave    bus
);
    import cpu_defs::*;

    wb_state_e     state_q, state_d;
    logic          we3_q, we3_d;
    logic [AW-1:0] wa3_q, wa3_d;
    logic [DW-1:0] wd3_q, wd3_d;

    // load context held across a miss
    logic          rw_q, rw_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [2:0]    lt_q, lt_d;
    logic [1:0]    addr_q, addr_d;

    logic          accept;
    logic [1:0]    ext_addr;
    logic [2:0]    ext_type;
    logic [31:0]   ext_data;

    assign accept = (state_q == ST_IDLE) && bus.mem_valid && !bus.flush;

    // a missed load extracts with its latched context; a hit uses the live MEM fields
    assign ext_addr = (state_q == ST_WAIT_DATA) ? addr_q : bus.mem_alu_result[1:0];
    assign ext_type = (state_q == ST_WAIT_DATA) ? lt_q   : bus.mem_load_type;

    load_extract u_load_extract (
        .word_i   (bus.dc_rdata),
        .addr_i   (ext_addr),
        .type_i   (ext_type),
        .result_o (ext_data)
    );

    always_comb begin
        state_d      = state_q;
        we3_d        = 1'b0;
        wa3_d        = wa3_q;
        wd3_d        = wd3_q;
        rw_d         = rw_q;
        wa_d         = wa_q;
        lt_d         = lt_q;
        addr_d       = addr_q;
        bus.wb_stall = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!bus.mem_memtoreg || bus.dc_data_ok) begin
                        // $0 is never written, but the port still tracks the instruction
                        we3_d = bus.mem_regwrite && (bus.mem_wa != '0);
                        wa3_d = bus.mem_wa;
                        wd3_d = bus.mem_memtoreg ? ext_data : bus.mem_alu_result;
                    end else begin
                        rw_d         = bus.mem_regwrite;
                        wa_d         = bus.mem_wa;
                        lt_d         = bus.mem_load_type;
                        addr_d       = bus.mem_alu_result[1:0];
                        bus.wb_stall = 1'b1;
                        state_d      = ST_WAIT_DATA;
                    end
                end
            end
            ST_WAIT_DATA: begin
                // flush is ignored here: the load has already left MEM in order
                if (bus.dc_data_ok) begin
                    we3_d   = rw_q && (wa_q != '0);
                    wa3_d   = wa_q;
                    wd3_d   = ext_data;
                    state_d = ST_IDLE;
                end else begin
                    bus.wb_stall = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we3_q   <= 1'b0;
            wa3_q   <= '0;
            wd3_q   <= '0;
            rw_q    <= 1'b0;
            wa_q    <= '0;
            lt_q    <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            we3_q   <= we3_d;
            wa3_q   <= wa3_d;
            wd3_q   <= wd3_d;
            rw_q    <= rw_d;
            wa_q    <= wa_d;
            lt_q    <= lt_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.we3       = we3_q;
    assign bus.wa3       = wa3_q;
    assign bus.wd3       = wd3_q;
    assign bus.fwd_valid = we3_q;
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline boundary of the MIPS CPU.
- Accepts one retiring instruction per cycle from the MEM stage. Collects load data from the data cache over a data_ok handshake and extracts/extends bytes and halfwords.
- Drives the register file write port (we3/wa3/wd3) one cycle after acceptance.
- Raises a stall while a load waits on a cache miss. Exports a forwarding copy of the pending write.

Parameters:
- DW, 32, datapath width.
- AW, 5, register address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_valid  in  1  MEM stage presents an instruction this cycle
- mem_regwrite  in  1  instruction writes a GPR
- mem_memtoreg  in  1  result comes from load data, not ALU
- mem_wa  in  AW  destination register
- mem_alu_result  in  DW  ALU result; for loads, the effective address
- mem_load_type  in  3  0=LW 1=LB 2=LBU 3=LH 4=LHU
- dc_data_ok  in  1  data cache returns read data this cycle
- dc_rdata  in  DW  data cache read word
- flush  in  1  exception/eret flush: kill the instruction being accepted
- wb_stall  out  1  freeze IF..MEM; high while a load waits for data
- we3  out  1  register file write enable
- wa3  out  AW  register file write address
- wd3  out  DW  register file write data
- fwd_valid  out  1  wa3/wd3 hold a write usable for forwarding (equals we3)

Behaviour:
- States: IDLE, WAIT_DATA.
- Reset: state=IDLE; we3=0, wa3=0, wd3=0, wb_stall=0, fwd_valid=0. Reset mid-WAIT_DATA abandons the load; a late dc_data_ok after reset is ignored.

IDLE, accept when mem_valid=1 and flush=0:
- Non-load (memtoreg=0): next cycle we3=regwrite & (mem_wa!=0), wa3=mem_wa, wd3=mem_alu_result.
- Load with dc_data_ok=1 same cycle: next cycle we3 as above, wd3=extract(dc_rdata).
- Load with dc_data_ok=0: latch wa/regwrite/load_type/addr[1:0], go to WAIT_DATA. wb_stall is combinational and high from this same cycle.
- No accept: next cycle we3=0. wa3/wd3 hold their last value.

WAIT_DATA:
- wb_stall=1; we3=0.
- On dc_data_ok=1: wb_stall drops combinationally that cycle. Next cycle write the extracted data and return to IDLE.
- flush during WAIT_DATA has no effect: the load is already committed in MEM order.
- MEM inputs are frozen by wb_stall and ignored.

Load extraction (little-endian, uses latched or live addr[1:0]):
- LW: whole word.
- LB/LBU: byte addr[1:0], sign-/zero-extended to 32.
- LH/LHU: halfword addr[1], sign-/zero-extended.
- addr[0] on halfword and addr[1:0] on word are ignored; alignment exceptions are raised upstream.
- Undefined load_type values 5-7 behave as LW.

Other rules:
- Latency: one cycle from acceptance (or data_ok) to we3 pulse; we3 is a single-cycle pulse per instruction.
- Writes to register 0: we3 forced 0, wa3/wd3 still updated.
- flush and mem_valid in the same cycle: instruction dropped, we3=0 next cycle.
- Back-to-back non-loads: one we3 pulse per cycle, no bubbles.

Decomposition:
- Shared package cpu_defs: load-type codes (LT_LW..LT_LHU), DW/AW constants, state encoding.
- One natural sub-module, load_extract: purely combinational, inputs (word, addr[1:0], type), output 32-bit result. It is reusable by the uncached path.

Test Plan:
- ALU write: mem_valid=1, regwrite=1, wa=5, alu=0x1234_5678, memtoreg=0 -> next cycle we3=1, wa3=5, wd3=0x1234_5678; following idle cycle we3=0.
- Cache-hit LB: addr=0x...03, load_type=LB, dc_data_ok=1, rdata=0x80FF_0011 -> next cycle wd3=0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- Miss LH: addr[1]=1, data_ok held 0 for 3 cycles -> wb_stall=1 for those 3 cycles, we3=0. data_ok=1 with rdata=0x8001_7FFF -> wb_stall=0 that cycle, next cycle wd3=0xFFFF_8001. LHU -> 0x0000_8001.
- $0 write: wa=0, regwrite=1 -> we3 stays 0.
- Flush: mem_valid=1, flush=1, wa=7 -> no we3. Flush raised during WAIT_DATA -> load still writes after data_ok.
- Reset mid-WAIT_DATA: rst for 1 cycle, then data_ok=1 -> outputs all 0, no we3, state IDLE.
